// File: rtl/regfile_mp_pkg.sv
// Shared types and limits for the multi-ported register file.
// Optional write-to-read bypass is selected with the REGFILE_BYPASS_EN macro.
`ifndef REGISTER_COUNT
`define REGISTER_COUNT 32
`endif

package regfile_mp_pkg;

  localparam int WordWidth = 32;
  localparam int RegCount = `REGISTER_COUNT;
  localparam int RegNumWidth = $clog2(RegCount);
  localparam int MAX_READ_PORTS = 4;
  localparam int MAX_WRITE_PORTS = 2;

  typedef logic [WordWidth-1:0] word;
  typedef logic [RegNumWidth-1:0] regnum;

  // Register 0 and addresses beyond the implemented range have no storage.
  function automatic logic reg_valid(regnum r, int count);
    return (r != '0) && (int'(r) < count);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read, write and issue signals between the pipeline and the register file.
// No handshakes: every field is sampled on each rising clock edge.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int ReadPorts = 2,
  parameter int WritePorts = 1
);
  regnum                 rd_reg  [ReadPorts];
  word                   rd_data [ReadPorts];
  logic [ReadPorts-1:0]  rd_busy;
  logic [WritePorts-1:0] wr_en;
  regnum                 wr_reg  [WritePorts];
  word                   wr_data [WritePorts];
  logic                  issue_en;
  regnum                 issue_reg;
  logic                  flush;

  modport master (
    output rd_reg, wr_en, wr_reg, wr_data, issue_en, issue_reg, flush,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_reg, wr_en, wr_reg, wr_data, issue_en, issue_reg, flush,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy bits: set on issue, cleared by writeback or flush,
// with a combinational lookup for each read port.
module regfile_mp_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int RegisterCount = RegCount,
  parameter int ReadPorts = 2,
  parameter int WritePorts = 1
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  issue_en,
  input  regnum                 issue_reg,
  input  logic                  flush,
  input  logic [WritePorts-1:0] wr_en,
  input  regnum                 wr_reg [WritePorts],
  input  regnum                 lookup_reg [ReadPorts],
  output logic [ReadPorts-1:0]  lookup_busy
);

  logic [RegisterCount-1:0] busy_q, busy_d;

  // Issue is applied after writeback-clear so a newer producer stays pending.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < WritePorts; w++) begin
      if (wr_en[w] && reg_valid(wr_reg[w], RegisterCount)) busy_d[wr_reg[w]] = 1'b0;
    end
    if (flush) begin
      busy_d = '0;
    end else if (issue_en && reg_valid(issue_reg, RegisterCount)) begin
      busy_d[issue_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    lookup_busy = '0;
    for (int r = 0; r < ReadPorts; r++) begin
      if (reg_valid(lookup_reg[r], RegisterCount)) lookup_busy[r] = busy_q[lookup_reg[r]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with busy scoreboard; r0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int RegisterCount = RegCount,
  parameter int ReadPorts = 2,
  parameter int WritePorts = 1
) (
  input logic clk,
  input logic res_n,
  regfile_mp_if.slave bus
);

  if (ReadPorts < 1 || ReadPorts > MAX_READ_PORTS ||
      WritePorts < 1 || WritePorts > MAX_WRITE_PORTS) begin : g_bad_ports
    $error("regfile_mp: unsupported port count");
  end

  word                  mem_q [RegisterCount];
  word                  mem_d [RegisterCount];
  logic [ReadPorts-1:0] sb_busy;

  // Ascending port order makes the highest-index writer win a collision.
  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < WritePorts; w++) begin
      if (bus.wr_en[w] && reg_valid(bus.wr_reg[w], RegisterCount)) begin
        mem_d[bus.wr_reg[w]] = bus.wr_data[w];
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  regfile_mp_scoreboard #(
    .RegisterCount(RegisterCount),
    .ReadPorts    (ReadPorts),
    .WritePorts   (WritePorts)
  ) u_scoreboard (
    .clk        (clk),
    .res_n      (res_n),
    .issue_en   (bus.issue_en),
    .issue_reg  (bus.issue_reg),
    .flush      (bus.flush),
    .wr_en      (bus.wr_en),
    .wr_reg     (bus.wr_reg),
    .lookup_reg (bus.rd_reg),
    .lookup_busy(sb_busy)
  );

  always_comb begin
    bus.rd_busy = '0;
    for (int r = 0; r < ReadPorts; r++) begin
      bus.rd_data[r] = '0;
      if (reg_valid(bus.rd_reg[r], RegisterCount)) begin
        bus.rd_data[r] = mem_q[bus.rd_reg[r]];
        bus.rd_busy[r] = sb_busy[r];
      end
`ifdef REGFILE_BYPASS_EN
      // Gated by res_n so reads stay zero while reset is held.
      if (res_n && reg_valid(bus.rd_reg[r], RegisterCount)) begin
        for (int w = 0; w < WritePorts; w++) begin
          if (bus.wr_en[w] && bus.wr_reg[w] == bus.rd_reg[r]) begin
            bus.rd_data[r] = bus.wr_data[w];
            bus.rd_busy[r] = 1'b0;
          end
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed test of regfile_mp with two read and two write ports.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int RP = 2;
  localparam int WP = 2;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  regfile_mp_if #(.ReadPorts(RP), .WritePorts(WP)) bus ();

  regfile_mp #(.RegisterCount(RegCount), .ReadPorts(RP), .WritePorts(WP)) dut (
    .clk  (clk),
    .res_n(res_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge; checks happen mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = '0;
    bus.issue_en = 1'b0;
    bus.flush = 1'b0;
    for (int w = 0; w < WP; w++) begin
      bus.wr_reg[w] = '0;
      bus.wr_data[w] = '0;
    end
    bus.issue_reg = '0;
  endtask

  task automatic set_rd(input int r0, input int r1);
    bus.rd_reg[0] = regnum'(r0);
    bus.rd_reg[1] = regnum'(r1);
  endtask

  task automatic wr(input int port, input int r, input logic [31:0] d);
    bus.wr_en[port] = 1'b1;
    bus.wr_reg[port] = regnum'(r);
    bus.wr_data[port] = d;
  endtask

  initial begin
    idle();
    set_rd(5, 3);
    tick();
    tick();
    check("reset_data0", bus.rd_data[0], 32'h0);
    check("reset_busy", 32'(bus.rd_busy), 32'h0);
    res_n = 1'b1;
    tick();

    // Write r3, read on both ports.
    set_rd(3, 3);
    wr(0, 3, 32'h1234_5678);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("wr_same_cycle", bus.rd_data[0], 32'h1234_5678);
`else
    check("wr_same_cycle", bus.rd_data[0], 32'h0);
`endif
    tick();
    idle();
    #1;
    check("wr_r3_p0", bus.rd_data[0], 32'h1234_5678);
    check("wr_r3_p1", bus.rd_data[1], 32'h1234_5678);

    // Writes to r0 are ignored.
    set_rd(0, 3);
    wr(0, 0, 32'hFFFF_FFFF);
    #1;
    check("r0_bypass", bus.rd_data[0], 32'h0);
    tick();
    idle();
    #1;
    check("r0_zero", bus.rd_data[0], 32'h0);
    check("r0_busy", 32'(bus.rd_busy[0]), 32'h0);

    // Same-register collision: port 1 wins.
    set_rd(7, 3);
    wr(0, 7, 32'h11);
    wr(1, 7, 32'h22);
    tick();
    idle();
    #1;
    check("collide_r7", bus.rd_data[0], 32'h22);

    // Issue r9 then write it back.
    set_rd(9, 3);
    bus.issue_en = 1'b1;
    bus.issue_reg = regnum'(9);
    #1;
    check("issue_not_yet", 32'(bus.rd_busy[0]), 32'h0);
    tick();
    idle();
    #1;
    check("issue_busy_r9", 32'(bus.rd_busy[0]), 32'h1);
    check("issue_other_r3", 32'(bus.rd_busy[1]), 32'h0);
    wr(1, 9, 32'h55);
    tick();
    idle();
    #1;
    check("wb_busy_r9", 32'(bus.rd_busy[0]), 32'h0);
    check("wb_data_r9", bus.rd_data[0], 32'h55);

    // Issue and write the same register: busy stays set.
    wr(0, 9, 32'h66);
    bus.issue_en = 1'b1;
    bus.issue_reg = regnum'(9);
    tick();
    idle();
    #1;
    check("iw_busy_r9", 32'(bus.rd_busy[0]), 32'h1);
    check("iw_data_r9", bus.rd_data[0], 32'h66);

    // Flush clears all busy bits, drops the issue, keeps the write.
    bus.issue_en = 1'b1;
    bus.issue_reg = regnum'(11);
    tick();
    idle();
    set_rd(11, 9);
    #1;
    check("pre_flush_r11", 32'(bus.rd_busy), 32'h3);
    bus.flush = 1'b1;
    bus.issue_en = 1'b1;
    bus.issue_reg = regnum'(10);
    wr(0, 12, 32'h77);
    tick();
    idle();
    set_rd(10, 11);
    #1;
    check("flush_r10_r11", 32'(bus.rd_busy), 32'h0);
    set_rd(9, 12);
    #1;
    check("flush_r9", 32'(bus.rd_busy[0]), 32'h0);
    check("flush_wr_r12", bus.rd_data[1], 32'h77);

    // Bypass behaviour on r4 with a pending producer.
    set_rd(4, 3);
    wr(0, 4, 32'h1234);
    tick();
    idle();
    bus.issue_en = 1'b1;
    bus.issue_reg = regnum'(4);
    tick();
    idle();
    wr(0, 4, 32'hCAFE);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_data", bus.rd_data[0], 32'hCAFE);
    check("byp_busy", 32'(bus.rd_busy[0]), 32'h0);
`else
    check("byp_data", bus.rd_data[0], 32'h1234);
    check("byp_busy", 32'(bus.rd_busy[0]), 32'h1);
`endif
    tick();
    idle();
    #1;
    check("byp_next_data", bus.rd_data[0], 32'hCAFE);
    check("byp_next_busy", 32'(bus.rd_busy[0]), 32'h0);

    // Asynchronous reset mid-run.
    set_rd(5, 3);
    wr(0, 5, 32'hDEAD_BEEF);
    tick();
    idle();
    bus.issue_en = 1'b1;
    bus.issue_reg = regnum'(5);
    tick();
    idle();
    #1;
    check("pre_rst_data", bus.rd_data[0], 32'hDEAD_BEEF);
    check("pre_rst_busy", 32'(bus.rd_busy[0]), 32'h1);
    #1;
    res_n = 1'b0;
    #1;
    check("rst_async_d0", bus.rd_data[0], 32'h0);
    check("rst_async_d1", bus.rd_data[1], 32'h0);
    check("rst_async_busy", 32'(bus.rd_busy), 32'h0);
    set_rd(6, 6);
    wr(0, 6, 32'hAB);
    #1;
    check("rst_wr_byp", bus.rd_data[0], 32'h0);
    tick();
    idle();
    res_n = 1'b1;
    tick();
    #1;
    check("rst_lost_wr_r6", bus.rd_data[0], 32'h0);
    set_rd(5, 3);
    #1;
    check("post_rst_r5", bus.rd_data[0], 32'h0);
    check("post_rst_r3", bus.rd_data[1], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
